// File: rtl/instr_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them to
// instruction RAM from address 0, appends the halt word if missing, then releases the CPU.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  cpu_run,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  error
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_APPEND = 2'd1,
    S_DONE   = 2'd2,
    S_ERROR  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;
  logic                  run_q, run_d;

  logic                  xfer_c;
  logic [4:0]            shamt_c;
  logic [31:0]           word_c;
  logic                  complete_c;
  logic                  full_c;
  logic [PTR_W-1:0]      wptr_inc_c;

  // Byte k lands at bit 8*(3-k); 3-k equals ~k for a 2-bit counter.
  assign xfer_c     = in_valid && in_ready_q;
  assign shamt_c    = {~cnt_q, 3'b000};
  assign word_c     = asm_q | (32'(in_byte) << shamt_c);
  assign complete_c = xfer_c && ((cnt_q == 2'd3) || in_last);
  assign full_c     = (wptr_q == DEPTH);
  assign wptr_inc_c = wptr_q + PTR_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: begin
        if (complete_c && full_c) begin
          state_d = S_ERROR;
        end else if (complete_c && in_last) begin
          if (word_c == HALT_WORD)       state_d = S_DONE;
          else if (wptr_inc_c == DEPTH)  state_d = S_ERROR;
          else                           state_d = S_APPEND;
        end
      end
      S_APPEND: state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    wptr_d     = wptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q | (state_d == S_ERROR);
    in_ready_d = (state_d == S_LOAD);
    run_d      = (state_d == S_DONE);
    unique case (state_q)
      S_LOAD: begin
        if (complete_c) begin
          cnt_d = 2'd0;
          asm_d = 32'd0;
          // A completion with no free slot is dropped; the FSM goes to ERROR.
          if (!full_c) begin
            we_d    = 1'b1;
            addr_d  = wptr_q[ADDR_WIDTH-1:0];
            wdata_d = word_c;
            wptr_d  = wptr_inc_c;
          end
        end else if (xfer_c) begin
          cnt_d = cnt_q + 2'd1;
          asm_d = word_c;
        end
      end
      S_APPEND: begin
        we_d    = 1'b1;
        addr_d  = wptr_q[ADDR_WIDTH-1:0];
        wdata_d = HALT_WORD;
        wptr_d  = wptr_inc_c;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 2'd0;
      asm_q      <= 32'd0;
      wptr_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      run_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      wptr_q     <= wptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      run_q      <= run_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign cpu_run    = run_q;
  assign word_count = wptr_q;
  assign error      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a 512-word instance and a 4-word instance,
// table-driven images plus hand-written reset and DONE sequences, with a write scoreboard.
module tb_instr_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_last = 1'b0;

  logic rdy_a, we_a, run_a, err_a;
  logic [8:0] addr_a;
  logic [31:0] wdata_a;
  logic [9:0] wc_a;
  logic rdy_b, we_b, run_b, err_b;
  logic [1:0] addr_b;
  logic [31:0] wdata_b;
  logic [2:0] wc_b;

  always #5 clk = ~clk;

  instr_loader dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_ready(rdy_a),
    .in_byte(in_byte), .in_last(in_last), .ram_we(we_a), .ram_addr(addr_a),
    .ram_wdata(wdata_a), .cpu_run(run_a), .word_count(wc_a), .error(err_a)
  );

  instr_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_ready(rdy_b),
    .in_byte(in_byte), .in_last(in_last), .ram_we(we_b), .ram_addr(addr_b),
    .ram_wdata(wdata_b), .cpu_run(run_b), .word_count(wc_b), .error(err_b)
  );

  logic rdy_m, we_m, run_m, err_m;
  logic [8:0] addr_m;
  logic [31:0] wdata_m;
  logic [9:0] wc_m;
  assign rdy_m   = sel ? rdy_b : rdy_a;
  assign we_m    = sel ? we_b : we_a;
  assign run_m   = sel ? run_b : run_a;
  assign err_m   = sel ? err_b : err_a;
  assign addr_m  = sel ? {7'd0, addr_b} : addr_a;
  assign wdata_m = sel ? wdata_b : wdata_a;
  assign wc_m    = sel ? {7'd0, wc_b} : wc_a;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected RAM writes, filled by the byte model as bytes are accepted.
  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  logic [31:0] mirror [512];
  int writes_seen = 0;

  int mcnt, mwp, depth;
  logic [31:0] mword;

  task automatic model_reset();
    mcnt = 0; mwp = 0; mword = 32'd0;
    depth = sel ? 4 : 512;
    q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic last);
    exp_t e;
    mword = mword | ({b, 24'h0} >> (8 * mcnt));
    if (mcnt == 3 || last) begin
      if (mwp < depth) begin
        e.addr = 9'(mwp); e.data = mword; q.push_back(e); mwp++;
        if (last && mword != HALT && mwp < depth) begin
          e.addr = 9'(mwp); e.data = HALT; q.push_back(e); mwp++;
        end
      end
      mcnt = 0; mword = 32'd0;
    end else begin
      mcnt++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && we_m) begin
      writes_seen++;
      mirror[addr_m] = wdata_m;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", addr_m, wdata_m);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(addr_m), 32'(e.addr));
        chk("wr_data", wdata_m, e.data);
      end
    end
  end

  task automatic do_reset(input logic s);
    @(negedge clk);
    reset = 1'b1; sel = s; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_byte = b; in_last = last;
    while (!rdy_m && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!rdy_m) begin
      errors++;
      $display("FAIL send_timeout: byte %h in_ready 0 expected 1", b);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_byte(b, last);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy"}, 32'(rdy_m), 32'd1);
    chk({tag, "_we"}, 32'(we_m), 32'd0);
    chk({tag, "_addr"}, 32'(addr_m), 32'd0);
    chk({tag, "_wdata"}, wdata_m, 32'd0);
    chk({tag, "_run"}, 32'(run_m), 32'd0);
    chk({tag, "_wc"}, 32'(wc_m), 32'd0);
    chk({tag, "_err"}, 32'(err_m), 32'd0);
  endtask

  typedef struct {
    logic        sel;
    int          n;
    logic [159:0] bytes;
    bit          toggle;
    int          exp_wc;
    bit          exp_run;
    bit          exp_err;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [8];

  initial begin : main
    logic [159:0] bv;
    int wc_before, seen_before;

    tbl[0] = '{1'b0, 8,  {64'h2008000520090007, 96'h0}, 1'b0, 3, 1'b1, 1'b0, 32'h20080005, 32'h20090007};
    tbl[1] = '{1'b0, 8,  {64'h11223344FFFFFFFF, 96'h0}, 1'b0, 2, 1'b1, 1'b0, 32'h11223344, 32'hFFFFFFFF};
    tbl[2] = '{1'b0, 5,  {40'hAABBCCDDEE, 120'h0},      1'b1, 3, 1'b1, 1'b0, 32'hAABBCCDD, 32'hEE000000};
    tbl[3] = '{1'b1, 16, {128'h000102030405060708090A0B0C0D0E0F, 32'h0}, 1'b0, 4, 1'b0, 1'b1, 32'h00010203, 32'h04050607};
    tbl[4] = '{1'b1, 20, 160'h000102030405060708090A0B0C0D0E0F10111213, 1'b0, 4, 1'b0, 1'b1, 32'h00010203, 32'h04050607};
    tbl[5] = '{1'b1, 12, {96'h000102030405060708090A0B, 64'h0}, 1'b0, 4, 1'b1, 1'b0, 32'h00010203, 32'h04050607};
    tbl[6] = '{1'b0, 3,  {24'hABCDEF, 136'h0},          1'b0, 2, 1'b1, 1'b0, 32'hABCDEF00, 32'hFFFFFFFF};
    tbl[7] = '{1'b0, 5,  {40'h0102030405, 120'h0},      1'b0, 3, 1'b1, 1'b0, 32'h01020304, 32'h05000000};

    do_reset(1'b0);
    chk_reset_state("rst");

    for (int i = 0; i < 8; i++) begin
      do_reset(tbl[i].sel);
      writes_seen = 0;
      bv = tbl[i].bytes;
      for (int j = 0; j < tbl[i].n; j++) begin
        send(bv[159 - 8*j -: 8], (j == tbl[i].n - 1));
        if (tbl[i].toggle) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_wc", i), 32'(wc_m), 32'(tbl[i].exp_wc));
      chk($sformatf("v%0d_writes", i), 32'(writes_seen), 32'(tbl[i].exp_wc));
      chk($sformatf("v%0d_run", i), 32'(run_m), 32'(tbl[i].exp_run));
      chk($sformatf("v%0d_err", i), 32'(err_m), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_rdy", i), 32'(rdy_m), 32'd0);
      chk($sformatf("v%0d_d0", i), mirror[0], tbl[i].d0);
      chk($sformatf("v%0d_d1", i), mirror[1], tbl[i].d1);
      chk($sformatf("v%0d_pending", i), 32'(q.size()), 32'd0);
    end

    // Reset after 6 accepted bytes, then a fresh image must start at byte 0, address 0.
    do_reset(1'b0);
    writes_seen = 0;
    for (int j = 0; j < 6; j++) send(8'(8'h40 + j), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_reset_state("midrst");
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b1);
    repeat (6) @(negedge clk);
    chk("midrst_d0", mirror[0], 32'h12345678);
    chk("midrst_d1", mirror[1], HALT);
    chk("midrst_wc", 32'(wc_m), 32'd2);
    chk("midrst_run", 32'(run_m), 32'd1);

    // In DONE, offered bytes are ignored.
    wc_before = 32'(wc_m);
    seen_before = writes_seen;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_byte = 8'(8'h55 + k); in_last = (k == 3);
      @(negedge clk);
      chk("done_rdy", 32'(rdy_m), 32'd0);
      chk("done_we", 32'(we_m), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_wc", 32'(wc_m), 32'(wc_before));
    chk("done_writes", 32'(writes_seen), 32'(seen_before));
    chk("done_run", 32'(run_m), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
